// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared unit codes, FSM states and width defaults for the ALU op sequencer
package alu_pkg;

  localparam int DEF_OPERAND_SIZE = 16;
  localparam int DEF_ALU_OUT      = 32;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESULT  = 2'b11
  } state_t;

  // Bit position in the enable/flag vectors equals the unit code.
  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    return 4'b0001 << unit;
  endfunction

endpackage

// File: rtl/alu_unit_decoder.sv
// rtl/alu_unit_decoder.sv - unit code to one-hot enables, result select and flag consistency check
module alu_unit_decoder
  import alu_pkg::*;
#(
  parameter int W = DEF_ALU_OUT
) (
  input  logic [1:0]   unit,
  input  logic         go,
  input  logic [W-1:0] arith_out,
  input  logic [W-1:0] logic_out,
  input  logic [W-1:0] cmp_out,
  input  logic [W-1:0] shift_out,
  input  logic [3:0]   flags,
  output logic [3:0]   enables,
  output logic [W-1:0] result,
  output logic         flag_err
);

  always_comb begin
    enables  = go ? unit_onehot(unit) : 4'b0000;
    // Only the addressed unit may report activity while it is being driven.
    flag_err = go && (flags != unit_onehot(unit));
    case (unit)
      UNIT_ARITH: result = arith_out;
      UNIT_LOGIC: result = logic_out;
      UNIT_CMP:   result = cmp_out;
      default:    result = shift_out;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU op at a time to the execution units and returns the result
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int OPERAND_SIZE = DEF_OPERAND_SIZE,
  parameter int ALU_OUT      = DEF_ALU_OUT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Req_Valid,
  output logic                    Req_Ready,
  input  logic [OPERAND_SIZE-1:0] Req_A,
  input  logic [OPERAND_SIZE-1:0] Req_B,
  input  logic [3:0]              Req_FUN,
  output logic [OPERAND_SIZE-1:0] A,
  output logic [OPERAND_SIZE-1:0] B,
  output logic [1:0]              ALU_FUN,
  output logic                    Arith_Enable,
  output logic                    Logic_Enable,
  output logic                    CMP_Enable,
  output logic                    Shift_Enable,
  input  logic [ALU_OUT-1:0]      Arith_OUT,
  input  logic [ALU_OUT-1:0]      Logic_OUT,
  input  logic [ALU_OUT-1:0]      CMP_OUT,
  input  logic [ALU_OUT-1:0]      Shift_OUT,
  input  logic                    Arith_Flag,
  input  logic                    Logic_Flag,
  input  logic                    CMP_Flag,
  input  logic                    Shift_Flag,
  output logic                    Res_Valid,
  input  logic                    Res_Ready,
  output logic [ALU_OUT-1:0]      Res_Data,
  output logic [1:0]              Res_Unit,
  output logic                    Err
);

  state_t             state;
  logic [1:0]         unit_q;
  logic [3:0]         enables;
  logic [ALU_OUT-1:0] sel_out;
  logic               flag_err;

  // In RESULT a new request is taken in the same edge the result is consumed.
  assign Req_Ready = (state == ST_IDLE) || ((state == ST_RESULT) && Res_Ready);

  // Enables decode straight from the state register so a reset drops them at once.
  alu_unit_decoder #(.W(ALU_OUT)) u_dec (
    .unit      (unit_q),
    .go        (state == ST_ISSUE),
    .arith_out (Arith_OUT),
    .logic_out (Logic_OUT),
    .cmp_out   (CMP_OUT),
    .shift_out (Shift_OUT),
    .flags     ({Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag}),
    .enables   (enables),
    .result    (sel_out),
    .flag_err  (flag_err)
  );

  assign Arith_Enable = enables[UNIT_ARITH];
  assign Logic_Enable = enables[UNIT_LOGIC];
  assign CMP_Enable   = enables[UNIT_CMP];
  assign Shift_Enable = enables[UNIT_SHIFT];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      unit_q    <= UNIT_ARITH;
      A         <= '0;
      B         <= '0;
      ALU_FUN   <= 2'b00;
      Res_Valid <= 1'b0;
      Res_Data  <= '0;
      Res_Unit  <= 2'b00;
      Err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req_Valid) begin
            A       <= Req_A;
            B       <= Req_B;
            ALU_FUN <= Req_FUN[1:0];
            unit_q  <= Req_FUN[3:2];
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (flag_err) Err <= 1'b1;
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          Res_Data  <= sel_out;
          Res_Unit  <= unit_q;
          Res_Valid <= 1'b1;
          state     <= ST_RESULT;
        end
        default: begin
          if (Res_Ready) begin
            Res_Valid <= 1'b0;
            if (Req_Valid) begin
              A       <= Req_A;
              B       <= Req_B;
              ALU_FUN <= Req_FUN[1:0];
              unit_q  <= Req_FUN[3:2];
              state   <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed scoreboard bench with behavioural execution units
module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic [15:0] Req_A = '0;
  logic [15:0] Req_B = '0;
  logic [3:0]  Req_FUN = '0;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [31:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        Res_Valid;
  logic        Res_Ready = 1'b1;
  logic [31:0] Res_Data;
  logic [1:0]  Res_Unit;
  logic        Err;
  logic        kill_logic = 1'b0;

  always #5 CLK = ~CLK;

  alu_op_sequencer dut (
    .CLK(CLK), .RST(RST),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_A(Req_A), .Req_B(Req_B), .Req_FUN(Req_FUN),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready),
    .Res_Data(Res_Data), .Res_Unit(Res_Unit), .Err(Err)
  );

  function automatic logic [31:0] unit_f(input logic [1:0] u, input logic [1:0] f,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [31:0] za, zb;
    za = {16'h0, a};
    zb = {16'h0, b};
    case (u)
      2'b00: case (f) 2'd0: return za + zb; 2'd1: return za - zb;
                      2'd2: return za * zb; default: return zb - za; endcase
      2'b01: case (f) 2'd0: return za & zb; 2'd1: return za | zb;
                      2'd2: return za ^ zb; default: return ~(za | zb); endcase
      2'b10: case (f) 2'd0: return {31'h0, a == b}; 2'd1: return {31'h0, a < b};
                      2'd2: return {31'h0, a > b};  default: return {31'h0, a != b}; endcase
      default: case (f) 2'd0: return za << b[3:0]; 2'd1: return za >> b[3:0];
                        2'd2: return za << 16;     default: return {a, b}; endcase
    endcase
  endfunction

  // Behavioural units: result registered one cycle after their enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Arith_OUT <= '0; Logic_OUT <= '0; CMP_OUT <= '0; Shift_OUT <= '0;
    end else begin
      if (Arith_Enable) Arith_OUT <= unit_f(2'b00, ALU_FUN, A, B);
      if (Logic_Enable) Logic_OUT <= unit_f(2'b01, ALU_FUN, A, B);
      if (CMP_Enable)   CMP_OUT   <= unit_f(2'b10, ALU_FUN, A, B);
      if (Shift_Enable) Shift_OUT <= unit_f(2'b11, ALU_FUN, A, B);
    end
  end

  assign Arith_Flag = Arith_Enable;
  assign Logic_Flag = Logic_Enable & ~kill_logic;
  assign CMP_Flag   = CMP_Enable;
  assign Shift_Flag = Shift_Enable;

  typedef struct { logic [31:0] data; logic [1:0] unit; } res_t;
  typedef struct { int edge_c; logic [1:0] unit; } acc_t;
  res_t exp_q[$];
  acc_t acc_q[$];
  int   acc_hist[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic [3:0] en;
  logic [3:0] prev_en = 4'b0;
  logic       prev_rv = 1'b0;
  assign en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

  always @(negedge CLK) begin
    if (!RST) begin
      if (en != 4'b0) begin
        check("en_onehot", {31'h0, $onehot(en)}, 32'd1);
        check("en_single_cycle", {28'h0, prev_en}, 32'd0);
        if (acc_q.size() == 0) check("en_without_accept", {28'h0, en}, 32'd0);
        else check("en_unit", {28'h0, en}, {28'h0, 4'b0001 << acc_q[0].unit});
      end
      if (Res_Valid && !prev_rv) begin
        if (acc_q.size() == 0) check("rv_without_accept", 32'd1, 32'd0);
        else begin
          acc_t a;
          a = acc_q.pop_front();
          check("latency", cyc - a.edge_c, 32'd2);
        end
      end
      if (Req_Valid && Req_Ready) begin
        acc_t n;
        n.edge_c = cyc + 1;
        n.unit   = Req_FUN[3:2];
        acc_q.push_back(n);
        acc_hist.push_back(cyc + 1);
      end
      if (Res_Valid && Res_Ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_result", 32'd1, 32'd0);
        else begin
          res_t r;
          r = exp_q.pop_front();
          check("sb_data", Res_Data, r.data);
          check("sb_unit", {30'h0, Res_Unit}, {30'h0, r.unit});
        end
      end
    end
    prev_en = en;
    prev_rv = Res_Valid;
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                      input bit keep);
    res_t r;
    int   n;
    Req_A = a; Req_B = b; Req_FUN = fun; Req_Valid = 1'b1;
    r.data = unit_f(fun[3:2], fun[1:0], a, b);
    r.unit = fun[3:2];
    exp_q.push_back(r);
    n = 0;
    @(negedge CLK);
    while (!Req_Ready && n < 30) begin
      @(negedge CLK);
      n++;
    end
    if (!Req_Ready) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    if (!keep) Req_Valid = 1'b0;
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (!Res_Valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("res_valid_timeout", {31'h0, Res_Valid}, 32'd1);
  endtask

  initial begin
    #1;
    check("rst_req_ready", {31'h0, Req_Ready}, 32'd1);
    check("rst_enables", {28'h0, en}, 32'd0);
    check("rst_a_b_fun", {A, B[13:0], ALU_FUN}, 32'd0);
    check("rst_res", {Res_Valid, Res_Unit, Err, Res_Data[27:0]}, 32'd0);
    check("rst_res_data", Res_Data, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    // logic AND
    send(16'hF0F0, 16'h0FF0, 4'b0100, 1'b0);
    check("t1_operand_a", {16'h0, A}, 32'h0000_F0F0);
    wait_rv();
    check("t1_res_data", Res_Data, 32'h0000_00F0);
    check("t1_res_unit", {30'h0, Res_Unit}, 32'd1);
    @(posedge CLK); #1;
    check("t1_consumed", {31'h0, Res_Valid}, 32'd0);

    // logic NOR
    send(16'h0000, 16'h0000, 4'b0111, 1'b0);
    wait_rv();
    check("t2_res_data", Res_Data, 32'hFFFF_FFFF);
    @(posedge CLK); #1;

    // result back-pressure
    Res_Ready = 1'b0;
    send(16'h1234, 16'h0005, 4'b0000, 1'b0);
    wait_rv();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("t3_hold_data", Res_Data, 32'h0000_1239);
      check("t3_hold_ready_en", {27'h0, Req_Ready, en}, 32'd0);
      check("t3_hold_valid", {31'h0, Res_Valid}, 32'd1);
    end
    @(posedge CLK); #1 Res_Ready = 1'b1;
    @(posedge CLK); #1;
    check("t3_consumed", {31'h0, Res_Valid}, 32'd0);
    check("t3_hold_a_b", {A, B}, 32'h1234_0005);

    // back-to-back
    acc_hist.delete();
    send(16'h0010, 16'h0003, 4'b0001, 1'b1);
    send(16'h0003, 16'h0007, 4'b1001, 1'b1);
    send(16'h0001, 16'h0004, 4'b1100, 1'b0);
    wait_rv();
    @(posedge CLK); #1;
    check("t4_accepts", acc_hist.size(), 32'd3);
    if (acc_hist.size() == 3) begin
      check("t4_spacing_1", acc_hist[1] - acc_hist[0], 32'd3);
      check("t4_spacing_2", acc_hist[2] - acc_hist[1], 32'd3);
    end

    // reset during ISSUE
    send(16'hABCD, 16'h1234, 4'b1110, 1'b0);
    check("t5_issue_enable", {31'h0, Shift_Enable}, 32'd1);
    RST = 1'b1;
    #1;
    check("t5_enable_drop", {28'h0, en}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("t5_no_res_valid", {31'h0, Res_Valid}, 32'd0);
    end
    @(posedge CLK); #1;
    send(16'h0003, 16'h0004, 4'b0010, 1'b0);
    wait_rv();
    check("t5_after_reset", Res_Data, 32'h0000_000C);
    @(posedge CLK); #1;
    check("t5_err_clear", {31'h0, Err}, 32'd0);

    // flag error
    kill_logic = 1'b1;
    send(16'h00FF, 16'h0F0F, 4'b0110, 1'b0);
    wait_rv();
    kill_logic = 1'b0;
    check("t6_err_set", {31'h0, Err}, 32'd1);
    check("t6_res_data", Res_Data, 32'h0000_0FF0);
    @(posedge CLK); #1;
    send(16'h0005, 16'h0005, 4'b1000, 1'b0);
    wait_rv();
    @(posedge CLK); #1;
    check("t6_err_sticky", {31'h0, Err}, 32'd1);
    RST = 1'b1;
    #1;
    check("t6_err_reset", {31'h0, Err}, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
